// File: rtl/packet_arbiter.sv
// packet_arbiter: shares one toggle req/ack flit channel between N requesters.
// Arbitration is round-robin per packet. Once an input is granted it owns the
// channel for exactly FLITS flits, so flits of different packets never mix.
// Every forwarded flit is checked against the head/body framing rule, and any
// violation sets a sticky error flag.
module packet_arbiter #(
  parameter int N     = 4,
  parameter int SIZE  = 8,
  parameter int FLITS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N-1:0]      in_req,
  output logic [N-1:0]      in_ack,
  input  logic [N*SIZE-1:0] in_data,
  output logic              out_req,
  input  logic              out_ack,
  output logic [SIZE-1:0]   out_data,
  output logic [N-1:0]      grant,
  output logic              err
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW:0]  NW   = (PW+1)'(N);
  localparam logic [PW-1:0] LAST_IDX  = PW'(N - 1);
  localparam logic [7:0]   LAST_FLIT = 8'(FLITS - 1);

  typedef enum logic [1:0] {IDLE, SEND, HOLD} state_t;

  state_t            r_state;
  logic [PW-1:0]     r_ptr;
  logic [PW-1:0]     r_sel;
  logic [7:0]        r_count;
  logic [N-1:0]      r_in_ack;
  logic [N-1:0]      r_grant;
  logic              r_out_req;
  logic [SIZE-1:0]   r_out_data;
  logic              r_err;

  logic [N-1:0]      w_pend;
  logic              w_any;
  logic [PW-1:0]     w_pick;
  logic [SIZE-1:0]   w_flit [N];
  logic [SIZE-1:0]   w_pick_data;
  logic [SIZE-1:0]   w_sel_data;

  // A flit at position 0 must carry the head marker; all later flits must not.
  function automatic logic framing_bad(input logic [SIZE-1:0] flit, input logic [7:0] cnt);
    if (cnt == 8'd0) return ~flit[SIZE-1];
    else             return flit[SIZE-1];
  endfunction

  function automatic logic [N-1:0] onehot(input logic [PW-1:0] idx);
    logic [N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] idx);
    if (idx == LAST_IDX) return '0;
    else                 return idx + 1'b1;
  endfunction

  // Pending uses the registered ack, so a flit acked this edge is never re-sent.
  assign w_pend = in_req ^ r_in_ack;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_unpack
      assign w_flit[gi] = in_data[gi*SIZE +: SIZE];
    end
  endgenerate

  // Round-robin pick: lowest pending index at or after the pointer, wrapping.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    for (int k = N - 1; k >= 0; k--) begin
      logic [PW:0] s;
      s = {1'b0, r_ptr} + (PW+1)'(k);
      if (s >= NW) s = s - NW;
      if (w_pend[s[PW-1:0]]) begin
        w_any  = 1'b1;
        w_pick = s[PW-1:0];
      end
    end
  end

  assign w_pick_data = w_flit[w_pick];
  assign w_sel_data  = w_flit[r_sel];

  // Packet FSM: arbitrate in IDLE, wait for sink ack in SEND, wait for the owner's next flit in HOLD.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_sel      <= '0;
      r_count    <= '0;
      r_in_ack   <= '0;
      r_grant    <= '0;
      r_out_req  <= 1'b0;
      r_out_data <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_sel      <= w_pick;
            r_grant    <= onehot(w_pick);
            r_out_data <= w_pick_data;
            r_out_req  <= ~r_out_req;
            if (framing_bad(w_pick_data, r_count)) r_err <= 1'b1;
            r_state    <= SEND;
          end
        end
        SEND: begin
          if (out_ack == r_out_req) begin
            r_in_ack[r_sel] <= ~r_in_ack[r_sel];
            if (r_count == LAST_FLIT) begin
              r_count <= '0;
              r_ptr   <= next_ptr(r_sel);
              r_grant <= '0;
              r_state <= IDLE;
            end else begin
              r_count <= r_count + 8'd1;
              r_state <= HOLD;
            end
          end
        end
        HOLD: begin
          // Only the owner is served until its packet completes.
          if (w_pend[r_sel]) begin
            r_out_data <= w_sel_data;
            r_out_req  <= ~r_out_req;
            if (framing_bad(w_sel_data, r_count)) r_err <= 1'b1;
            r_state    <= SEND;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ack   = r_in_ack;
  assign out_req  = r_out_req;
  assign out_data = r_out_data;
  assign grant    = r_grant;
  assign err      = r_err;

endmodule
